regfile_mp: RTL



---
 rtl/regfile_mp.sv | 131 +++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with write-to-read bypass,
// an optional hardwired-zero register 0 and a per-register pending scoreboard.
// Decode reads and reserves destination registers; writeback writes and
// releases them. A registered flag reports same-address write collisions.
module regfile_mp #(
    parameter int  WIDTH    = 8,
    parameter int  DEPTH    = 4,
    parameter int  NREAD    = 2,
    parameter int  NWRITE   = 2,
    parameter int  BYPASS   = 1,
    parameter int  ZERO_REG = 0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NWRITE-1:0]       we,
    input  logic [NWRITE*AW-1:0]    waddr,
    input  logic [NWRITE*WIDTH-1:0] wdata,
    input  logic [NREAD*AW-1:0]     raddr,
    output logic [NREAD*WIDTH-1:0]  rdata,
    output logic [NREAD-1:0]        rbusy,
    input  logic                    rsv_valid,
    input  logic [AW-1:0]           rsv_addr,
    output logic                    rsv_ok,
    output logic                    wr_conflict
);

    // Architectural state.
    logic [WIDTH-1:0]  data_q [DEPTH];
    logic [DEPTH-1:0]  pending_q;
    logic              wr_conflict_q;

    // Next-state values and per-cycle decode.
    logic [WIDTH-1:0]  data_d [DEPTH];
    logic [DEPTH-1:0]  pending_d;
    logic [NWRITE-1:0] wr_en;     // write enables with register-0 writes removed
    logic              collide;   // two or more live ports share an address
    logic              rsv_keep;  // accepted reservation that really sets a bit

    // Drop writes aimed at the hardwired zero register before anything else sees them.
    always_comb begin
        for (int i = 0; i < NWRITE; i++) begin
            wr_en[i] = we[i] && !(ZERO_REG != 0 && waddr[i*AW +: AW] == '0);
        end
    end

    // Detect any pair of live write ports targeting the same register.
    always_comb begin
        // NOTE: a default is assigned before the conditional updates so every path
        // drives the signal and no latch is inferred.
        collide = 1'b0;
        for (int i = 0; i < NWRITE; i++) begin
            for (int k = i + 1; k < NWRITE; k++) begin
                if (wr_en[i] && wr_en[k] && waddr[i*AW +: AW] == waddr[k*AW +: AW]) begin
                    collide = 1'b1;
                end
            end
        end
    end

    // A reservation is accepted only when the register is idle before the edge,
    // even if a write would release it this same cycle.
    assign rsv_ok   = rst_n && rsv_valid && !pending_q[rsv_addr];
    assign rsv_keep = rsv_ok && !(ZERO_REG != 0 && rsv_addr == '0);

    // Next state: writes in ascending port order so the highest port wins a
    // collision, then an accepted reservation sets pending on top of any clear.
    always_comb begin
        data_d    = data_q;
        pending_d = pending_q;
        for (int i = 0; i < NWRITE; i++) begin
            if (wr_en[i]) begin
                data_d[waddr[i*AW +: AW]]    = wdata[i*WIDTH +: WIDTH];
                pending_d[waddr[i*AW +: AW]] = 1'b0;
            end
        end
        if (rsv_keep) begin
            pending_d[rsv_addr] = 1'b1;
        end
    end

    // Read ports: stored value, optionally overridden by the highest same-cycle
    // writer; register 0 and the whole port are forced to zero where required.
    always_comb begin : read_ports
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] rv;
        rdata = '0;
        rbusy = '0;
        ra    = '0;
        rv    = '0;
        for (int j = 0; j < NREAD; j++) begin
            ra = raddr[j*AW +: AW];
            rv = data_q[ra];
            if (BYPASS != 0) begin
                for (int i = 0; i < NWRITE; i++) begin
                    if (wr_en[i] && waddr[i*AW +: AW] == ra) begin
                        rv = wdata[i*WIDTH +: WIDTH];
                    end
                end
            end
            if (!rst_n || (ZERO_REG != 0 && ra == '0)) begin
                rv = '0;
            end
            rdata[j*WIDTH +: WIDTH] = rv;
            rbusy[j]                = rst_n && pending_q[ra];
        end
    end

    // State registers: data array, scoreboard and the collision pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data array is cleared on reset because every register must
            // read 0 after reset; this keeps it as resettable flops, not a RAM.
            for (int r = 0; r < DEPTH; r++) begin
                data_q[r] <= '0;
            end
            pending_q     <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops
            // sample pre-edge values; the combinational blocks above use blocking
            // assignments because later ports must overwrite earlier ones.
            data_q        <= data_d;
            pending_q     <= pending_d;
            wr_conflict_q <= collide;
        end
    end

    assign wr_conflict = wr_conflict_q;

endmodule
